// File: rtl/banco_arbitro.sv
// Write-port controller for the 32x32 register file: boots fixed values, then
// round-robin arbitrates two writeback requesters. Optional: BANCO_ARB_ZERO_PROTECT_EN.
module banco_arbitro #(
  parameter int size = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req0_valid,
  input  logic [4:0]      req0_reg,
  input  logic [size-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_reg,
  input  logic [size-1:0] req1_data,
  output logic            req1_ready,
  output logic            RegWrite,
  output logic [4:0]      WriteReg,
  output logic [size-1:0] WriteData,
  output logic            init_done,
  output logic            last_grant
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  localparam logic [2:0] BOOT_LAST = 3'd6;

  state_t          state_q, state_d;
  logic [2:0]      init_ptr_q, init_ptr_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      wreg_q, wreg_d;
  logic [size-1:0] wdata_q, wdata_d;
  logic            last_grant_q, last_grant_d;

  logic            gnt0, gnt1, xfer;
  logic [4:0]      sel_reg;
  logic [size-1:0] sel_data;

  function automatic logic [4:0] boot_reg(input logic [2:0] i);
    case (i)
      3'd0:    boot_reg = 5'd8;
      3'd1:    boot_reg = 5'd9;
      3'd2:    boot_reg = 5'd10;
      3'd3:    boot_reg = 5'd12;
      3'd4:    boot_reg = 5'd16;
      3'd5:    boot_reg = 5'd17;
      default: boot_reg = 5'd18;
    endcase
  endfunction

  function automatic logic [2:0] boot_val(input logic [2:0] i);
    case (i)
      3'd0:    boot_val = 3'd5;
      3'd1:    boot_val = 3'd5;
      3'd2:    boot_val = 3'd1;
      3'd3:    boot_val = 3'd4;
      3'd4:    boot_val = 3'd1;
      3'd5:    boot_val = 3'd3;
      default: boot_val = 3'd1;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= INIT;
      init_ptr_q   <= 3'd0;
      regwrite_q   <= 1'b0;
      wreg_q       <= 5'd0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      regwrite_q   <= regwrite_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_ptr_q == BOOT_LAST) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == RUN) begin
      // On a tie the requester that did not win last time goes next
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
    xfer     = gnt0 | gnt1;
    sel_reg  = gnt1 ? req1_reg  : req0_reg;
    sel_data = gnt1 ? req1_data : req0_data;

    init_ptr_d   = init_ptr_q;
    regwrite_d   = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    if (state_q == INIT) begin
      regwrite_d = 1'b1;
      wreg_d     = boot_reg(init_ptr_q);
      wdata_d    = {{(size-3){1'b0}}, boot_val(init_ptr_q)};
      init_ptr_d = init_ptr_q + 3'd1;
    end else if (xfer) begin
`ifdef BANCO_ARB_ZERO_PROTECT_EN
      regwrite_d = (sel_reg != 5'd0);
`else
      regwrite_d = 1'b1;
`endif
      wreg_d       = sel_reg;
      wdata_d      = sel_data;
      last_grant_d = gnt1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign RegWrite   = regwrite_q;
  assign WriteReg   = wreg_q;
  assign WriteData  = wdata_q;
  assign init_done  = (state_q == RUN);
  assign last_grant = last_grant_q;

endmodule
